uart_frame_packer: RTL

- Parametrised successor to the fixed 15-byte lamp/counter UART dump: serialises a wide snapshot bus into a framed byte stream for the Uart transmitter's TxData/TxData_valid/TxData_ready handshake.
- Frame is `[HEADER] payload bytes MSB-first [CHECKSUM] TAIL`. The header and checksum bytes are each optional.
- Started by either edge of a slow trigger level (e.g. the lamp tick), with a one-deep pending queue and overrun accounting.
- Sits between the display/lamp logic and the Uart block in the top level.

---
 rtl/uart_frame_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - serialises a payload snapshot into a framed UART byte stream
module uart_frame_packer #(
  parameter int         PAYLOAD_BYTES = 14,
  parameter int         HEADER_EN     = 0,
  parameter logic [7:0] HEADER_BYTE   = 8'hA5,
  parameter int         CHECKSUM_EN   = 1,
  parameter logic [7:0] TAIL_BYTE     = 8'hEE
) (
  input  logic                       Sys_CLK,
  input  logic                       Sys_RST,
  input  logic                       trigger,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 overrun_cnt
);

  localparam int            IW       = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK,
    ST_TAIL
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       trigger_q;
  logic                       req;
  logic                       pending;
  logic                       start;
  logic                       xfer;
  logic [IW-1:0]              idx;
  logic [7:0]                 csum;
  logic [7:0]                 cur_byte;
  logic [8*PAYLOAD_BYTES-1:0] snapshot;

  // Every state except IDLE is presenting a byte, so valid is a pure state decode;
  // this also makes tx_valid fall asynchronously with the reset.
  assign tx_valid = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign xfer     = tx_valid && tx_ready;
  assign req      = trigger ^ trigger_q;
  assign start    = (state == ST_IDLE) && (req || pending);
  // The snapshot shifts left as bytes go out, so the next payload byte is always on top.
  assign cur_byte = snapshot[8*PAYLOAD_BYTES-1 -: 8];

  // Edge detector history; loaded from the live level in reset so release never fires a frame.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      trigger_q <= trigger;
    end else begin
      trigger_q <= trigger;
    end
  end

  // Frame state register.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the byte presented in each state.
  always_comb begin
    state_nxt = state;
    tx_data   = TAIL_BYTE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
        end
      end
      ST_HEADER: begin
        tx_data = HEADER_BYTE;
        if (xfer) begin
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        tx_data = cur_byte;
        if (xfer && (idx == LAST_IDX)) begin
          state_nxt = (CHECKSUM_EN != 0) ? ST_CHECK : ST_TAIL;
        end
      end
      ST_CHECK: begin
        tx_data = csum;
        if (xfer) begin
          state_nxt = ST_TAIL;
        end
      end
      ST_TAIL: begin
        tx_data = TAIL_BYTE;
        if (xfer) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Snapshot capture at frame start, then shift-out with running checksum and byte index.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      snapshot <= '0;
      csum     <= 8'h00;
      idx      <= '0;
    end else if (start) begin
      snapshot <= payload;
      csum     <= 8'h00;
      idx      <= '0;
    end else if ((state == ST_PAYLOAD) && xfer) begin
      snapshot <= snapshot << 8;
      csum     <= csum + cur_byte;
      idx      <= idx + IW'(1);
    end
  end

  // One-deep request queue; a request arriving while one is already queued is counted as dropped.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      pending     <= 1'b0;
      overrun_cnt <= 8'h00;
    end else if (start) begin
      // A fresh toggle in the same cycle the queued request is consumed stays queued.
      pending <= pending && req;
    end else if (req) begin
      if (!pending) begin
        pending <= 1'b1;
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'h01;
      end
    end
  end

  // Completion strobe for the cycle after the tail byte is accepted.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_TAIL) && xfer;
    end
  end

endmodule
